disp_bcd_ctrl: RTL
==================

DISP_BCD_CTRL -- requirements
Module: disp_bcd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the unsigned input word width (range 4..16).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 3, meaning the number of seven-segment digits driven (range 1..5).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: one-cycle write strobe, typically the slave's internal write enable.
REQ-006 The block SHALL have port wr_data, input, DATA_WIDTH bits: the value to display, sampled with wr_en.
REQ-007 The block SHALL have port hex_mode, input, 1 bit: sampled with wr_en; 1 = hexadecimal display, 0 = decimal display.
REQ-008 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of the overrun flag.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when seg_out updates.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set when a write is dropped.
REQ-012 The block SHALL have port range_err, output, 1 bit: set when the last value did not fit in NUM_DIGITS digits.
REQ-013 The block SHALL have port seg_out, output, 7*NUM_DIGITS bits: active-low segments; digit i occupies bits [7i+6:7i], bit 0 = a ... bit 6 = g; digit 0 is least significant.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT and LATCH; busy SHALL be high in SHIFT and LATCH.
REQ-015 In IDLE, wr_en=1 at edge k SHALL load wr_data and hex_mode and clear the BCD accumulator; the next state SHALL be SHIFT (decimal) or LATCH (hex).
REQ-016 In SHIFT, the block SHALL run one double-dabble step per cycle (add 3 to each accumulator nibble >=5, then shift left, taking in the data MSB), for exactly DATA_WIDTH cycles, then go to LATCH.
REQ-017 The accumulator SHALL hold enough nibbles for ceil(DATA_WIDTH*log10(2)) decimal digits, so that no intermediate overflow occurs.
REQ-018 In LATCH, the block SHALL register the digits into seg_out, pulse done, update range_err and return to IDLE.
REQ-019 Latency from the wr_en edge to seg_out valid SHALL be DATA_WIDTH+1 cycles in decimal mode and 1 cycle in hex mode.
REQ-020 A wr_en received while busy=1 SHALL be dropped, set overrun, and leave the conversion unaffected.
REQ-021 ovf_clr SHALL clear overrun; if ovf_clr and a dropped write occur in the same cycle, overrun SHALL be set (set wins).
REQ-022 A decimal value with a nonzero BCD digit at index >= NUM_DIGITS, or a hex value with a nonzero nibble at index >= NUM_DIGITS, SHALL set range_err=1 and drive every digit to minus (7'b0111111).
REQ-023 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
REQ-024 seg_out, range_err and the digit registers SHALL change only in LATCH; outputs SHALL hold between writes.

Reset
REQ-025 When rstn=0, the block SHALL asynchronously force the FSM to IDLE and set busy=0, done=0, overrun=0, range_err=0, and every seg_out digit to blank.
REQ-026 A reset asserted mid-conversion SHALL abort the conversion with no done pulse; after release, the first wr_en SHALL be accepted normally.

Configuration
REQ-027 With macro DISP_LZB_EN defined, the block SHALL blank leading zero digits above digit 0 (digit 0 always shown; range_err minus pattern never blanked).
REQ-028 Without DISP_LZB_EN, the block SHALL show every digit including leading zeros.

Verification (DATA_WIDTH=8, NUM_DIGITS=3 unless stated)
REQ-029 wr_data=255, hex_mode=0 -> busy for 9 cycles; done at cycle 9; digits 2,5,5 (0100100, 0010010, 0010010); range_err=0.
REQ-030 wr_data=8'hA5, hex_mode=1 -> done after 1 cycle; digit0=5, digit1=A, digit2=0 without DISP_LZB_EN and blank with it.
REQ-031 wr_data=7, decimal, with DISP_LZB_EN -> digit0=7, digits 1-2 blank; without the macro -> 0,0,7.
REQ-032 wr_data=100, then wr_en again 3 cycles later with 50 -> second write dropped; overrun=1; display shows 100; ovf_clr -> overrun=0.
REQ-033 With NUM_DIGITS=2, wr_data=200 -> range_err=1 and both digits 0111111; a following write of 42 -> range_err=0, display 42.
REQ-034 rstn pulsed low at SHIFT cycle 4 of a write of 123 -> all digits blank, busy=0, no done pulse; a next write of 9 -> display 009 (or blank-blank-9 with DISP_LZB_EN).

Source files
------------

// File: rtl/disp_bcd_ctrl.sv
// Binary-to-seven-segment display controller: double-dabble for decimal, direct nibbles for hex.
// Optional leading-zero blanking is enabled with macro DISP_LZB_EN.
module disp_bcd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    hex_mode,
  input  logic                    ovf_clr,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic                    range_err,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (v > 0) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  localparam int BCD_DIGITS = dec_digits(DATA_WIDTH);
  localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
  // Digit source is padded so every nibble index below is in range for any parameter mix.
  localparam int PAD_DIGITS = max3(BCD_DIGITS, HEX_DIGITS, NUM_DIGITS);
  localparam int CW         = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    hex_q;
  logic [4*BCD_DIGITS-1:0] acc;
  logic [4*BCD_DIGITS-1:0] acc_adj;
  logic [4*BCD_DIGITS-1:0] acc_shl;
  logic [4*PAD_DIGITS-1:0] src_pad;
  logic                    range_nxt;
  logic [7*NUM_DIGITS-1:0] seg_nxt;

  assign busy = (state != IDLE);

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_shl = {acc_adj[4*BCD_DIGITS-2:0], data_q[DATA_WIDTH-1]};
  end

  always_comb begin
    src_pad = '0;
    if (hex_q) src_pad[DATA_WIDTH-1:0] = data_q;
    else       src_pad[4*BCD_DIGITS-1:0] = acc;
    range_nxt = 1'b0;
    for (int i = 0; i < PAD_DIGITS; i++) begin
      if (i >= NUM_DIGITS && src_pad[4*i +: 4] != 4'd0) range_nxt = 1'b1;
    end
  end

  always_comb begin
`ifdef DISP_LZB_EN
    logic lead;
`endif
    seg_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_nxt[7*i +: 7] = range_nxt ? SEG_MINUS : seg7(src_pad[4*i +: 4]);
    end
`ifdef DISP_LZB_EN
    // Walk down from the top digit; zeros stay blank until the first nonzero digit.
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (src_pad[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && !range_nxt) seg_nxt[7*i +: 7] = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      hex_q     <= 1'b0;
      acc       <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      range_err <= 1'b0;
      seg_out   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      done <= 1'b0;
      if (busy && wr_en)  overrun <= 1'b1;
      else if (ovf_clr)   overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            data_q <= wr_data;
            hex_q  <= hex_mode;
            acc    <= '0;
            cnt    <= '0;
            state  <= hex_mode ? LATCH : SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_shl;
          data_q <= {data_q[DATA_WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_STEP) state <= LATCH;
        end
        LATCH: begin
          seg_out   <= seg_nxt;
          range_err <= range_nxt;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
